// File: rtl/instr_mem_fetch_if.sv
// Fetch-side bus of the instruction memory: request/response handshake plus the program-load port.
interface instr_mem_fetch_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  flush;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_instr;
   logic [ADDR_WIDTH-1:0] resp_addr;
   logic [1:0]            resp_fault;
   logic                  load_en;
   logic [ADDR_WIDTH-1:0] load_addr;
   logic [DATA_WIDTH-1:0] load_data;

   modport master (
      output req_valid, req_addr, flush, resp_ready, load_en, load_addr, load_data,
      input  req_ready, resp_valid, resp_instr, resp_addr, resp_fault
   );

   modport slave (
      input  req_valid, req_addr, flush, resp_ready, load_en, load_addr, load_data,
      output req_ready, resp_valid, resp_instr, resp_addr, resp_fault
   );
endinterface

// File: rtl/instr_mem_fetch.sv
// Instruction memory with synchronous block-RAM read, registered valid/ready response,
// flush, fault flagging and a runtime program-load write port.
module instr_mem_fetch #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    DEPTH       = 1024,
   parameter string                 INIT_FILE   = "",
   parameter logic [DATA_WIDTH-1:0] FAULT_INSTR = 32'h00000013
) (
   input logic                 clk,
   input logic                 reset,
   instr_mem_fetch_if.slave    bus
);
   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int OFF_W  = (BYTES > 1) ? $clog2(BYTES) : 0;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);

   // bit0 = misaligned, bit1 = out of range; no aliasing past DEPTH
   function automatic logic [1:0] fault_of(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] idx;
      idx = a >> OFF_W;
      return {idx >= DEPTH_A, (a & OFF_MASK) != '0};
   endfunction

   function automatic logic [MEM_AW-1:0] index_of(input logic [ADDR_WIDTH-1:0] a);
      return MEM_AW'(a >> OFF_W);
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   end

   logic [1:0]            req_fault;
   logic [1:0]            ld_fault;
   logic                  req_ready;
   logic                  accept;
   logic                  vld_p1;
   logic [ADDR_WIDTH-1:0] addr_p1;
   logic [1:0]            fault_p1;
   logic [DATA_WIDTH-1:0] ram_p1;

   assign req_fault = fault_of(bus.req_addr);
   assign ld_fault  = fault_of(bus.load_addr);
   assign req_ready = !reset && !bus.flush && !bus.load_en && (!vld_p1 || bus.resp_ready);
   assign accept    = bus.req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (bus.load_en && (ld_fault == 2'b00))
         mem[index_of(bus.load_addr)] <= bus.load_data;
   end

   // stage p0 -> p1: RAM read only on a clean accept, so a stall leaves the RAM output frozen
   always_ff @(posedge clk) begin
      if (reset)
         ram_p1 <= '0;
      else if (accept && (req_fault == 2'b00))
         ram_p1 <= mem[index_of(bus.req_addr)];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1   <= 1'b0;
         addr_p1  <= '0;
         fault_p1 <= 2'b00;
      end else if (accept) begin
         vld_p1   <= 1'b1;
         addr_p1  <= bus.req_addr;
         fault_p1 <= req_fault;
      end else if (bus.flush || bus.resp_ready) begin
         vld_p1   <= 1'b0;
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = vld_p1;
   assign bus.resp_addr  = addr_p1;
   assign bus.resp_fault = fault_p1;
   assign bus.resp_instr = (fault_p1 != 2'b00) ? FAULT_INSTR : ram_p1;
endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch: scoreboard of expected responses plus a reference memory image.
module tb_instr_mem_fetch;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   instr_mem_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   instr_mem_fetch #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .INIT_FILE(""), .FAULT_INSTR(32'h00000013)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int total = 0;
   int bad = 0;
   logic [65:0] sbq[$];
   logic [31:0] mm [1024];
   logic        m_vld = 1'b0;

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {fault[1:0], addr[31:0], instr[31:0]}
   function automatic logic [65:0] exp_of(input logic [31:0] a);
      logic [1:0] f;
      f = {(a >> 2) >= 32'd1024, a[1:0] != 2'b00};
      return {f, a, (f != 2'b00) ? 32'h00000013 : mm[a[11:2]]};
   endfunction

   task automatic cyc(input logic rv, input logic [31:0] ra, input logic rr, input logic fl,
                      input logic le, input logic [31:0] la, input logic [31:0] ld);
      logic rdy, acc, hold;
      logic [65:0] snap, want;
      bus.req_valid  = rv;
      bus.req_addr   = ra;
      bus.resp_ready = rr;
      bus.flush      = fl;
      bus.load_en    = le;
      bus.load_addr  = la;
      bus.load_data  = ld;
      #1;
      rdy = !fl && !le && (!m_vld || rr);
      chk("req_ready", {65'd0, bus.req_ready}, {65'd0, rdy});
      acc  = rv && rdy;
      hold = m_vld && !rr && !fl;
      snap = {bus.resp_fault, bus.resp_addr, bus.resp_instr};
      if (m_vld && sbq.size() > 0) begin
         if (fl) void'(sbq.pop_front());
         else if (rr) begin
            want = sbq.pop_front();
            chk("resp", snap, want);
         end
      end
      if (acc) sbq.push_back(exp_of(ra));
      if (le && la[1:0] == 2'b00 && (la >> 2) < 32'd1024) mm[la[11:2]] = ld;
      m_vld = acc ? 1'b1 : ((fl || rr) ? 1'b0 : m_vld);
      @(posedge clk);
      #1;
      chk("resp_valid", {65'd0, bus.resp_valid}, {65'd0, m_vld});
      if (hold) chk("hold", {bus.resp_fault, bus.resp_addr, bus.resp_instr}, snap);
   endtask

   task automatic do_reset();
      bus.req_valid  = 1'b1;
      bus.req_addr   = 32'h0;
      bus.resp_ready = 1'b0;
      bus.flush      = 1'b0;
      bus.load_en    = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_req_ready", {65'd0, bus.req_ready}, 66'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_valid", {65'd0, bus.resp_valid}, 66'd0);
      chk("rst_instr", {34'd0, bus.resp_instr}, 66'd0);
      chk("rst_addr", {34'd0, bus.resp_addr}, 66'd0);
      chk("rst_fault", {64'd0, bus.resp_fault}, 66'd0);
      sbq.delete();
      m_vld = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mm[i] = 32'h0;
      bus.req_valid = 1'b0; bus.req_addr = 32'h0; bus.resp_ready = 1'b0; bus.flush = 1'b0;
      bus.load_en = 1'b0; bus.load_addr = 32'h0; bus.load_data = 32'h0;
      @(posedge clk);
      #1;
      do_reset();

      // program image through the load port
      cyc(0, 0, 1, 0, 1, 32'h0, 32'h00500093);
      cyc(0, 0, 1, 0, 1, 32'h4, 32'h00a00113);
      cyc(0, 0, 1, 0, 1, 32'h8, 32'h002081b3);

      // back-to-back fetches
      cyc(1, 32'h0, 1, 0, 0, 0, 0);
      cyc(1, 32'h4, 1, 0, 0, 0, 0);
      cyc(1, 32'h8, 1, 0, 0, 0, 0);
      cyc(0, 32'h0, 1, 0, 0, 0, 0);

      // back-pressure stall then release
      cyc(1, 32'h4, 1, 0, 0, 0, 0);
      repeat (3) cyc(1, 32'h8, 0, 0, 0, 0, 0);
      cyc(1, 32'h8, 1, 0, 0, 0, 0);
      cyc(0, 32'h0, 1, 0, 0, 0, 0);

      // faulting fetches
      cyc(1, 32'h6, 1, 0, 0, 0, 0);
      cyc(1, 32'h1000, 1, 0, 0, 0, 0);
      cyc(1, 32'h1002, 1, 0, 0, 0, 0);
      cyc(0, 32'h0, 1, 0, 0, 0, 0);

      // load blocks accept; next-cycle fetch sees new data; bad loads ignored
      cyc(1, 32'h10, 1, 0, 1, 32'h10, 32'hdeadbeef);
      cyc(1, 32'h10, 1, 0, 0, 0, 0);
      cyc(0, 32'h0, 1, 0, 1, 32'h12, 32'h11111111);
      cyc(0, 32'h0, 1, 0, 1, 32'h1000, 32'h22222222);
      cyc(1, 32'h10, 1, 0, 0, 0, 0);
      cyc(1, 32'h0, 1, 0, 0, 0, 0);
      cyc(0, 32'h0, 1, 0, 0, 0, 0);

      // held response keeps old data across a load to its own address
      cyc(1, 32'h10, 1, 0, 0, 0, 0);
      cyc(0, 32'h0, 0, 0, 1, 32'h10, 32'h12345678);
      cyc(0, 32'h0, 1, 0, 0, 0, 0);
      cyc(1, 32'h10, 1, 0, 0, 0, 0);
      cyc(0, 32'h0, 1, 0, 0, 0, 0);

      // flush while stalled
      cyc(1, 32'h8, 1, 0, 0, 0, 0);
      cyc(1, 32'h4, 0, 1, 0, 0, 0);
      cyc(1, 32'h4, 1, 0, 0, 0, 0);
      cyc(0, 32'h0, 1, 0, 0, 0, 0);

      // flush and load together
      cyc(1, 32'h0, 1, 0, 0, 0, 0);
      cyc(1, 32'h0, 1, 1, 1, 32'h20, 32'hcafef00d);
      cyc(1, 32'h20, 1, 0, 0, 0, 0);
      cyc(0, 32'h0, 1, 0, 0, 0, 0);

      // reset mid-stream; memory survives
      cyc(1, 32'h0, 1, 0, 0, 0, 0);
      do_reset();
      cyc(1, 32'h10, 1, 0, 0, 0, 0);
      cyc(0, 32'h0, 1, 0, 0, 0, 0);

      chk("sb_empty", 66'(sbq.size()), 66'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
